// File: rtl/wb_stage.sv
// Write-back stage of the 5-stage RISC-V core.
//
// Holds the MEM/WB pipeline register and selects the result written back:
// ALU result, an aligned and extended load value, or the PC+4 link value.
// The result drives the register-file write port. A 64-bit counter
// records retired instructions.
//
// Ports:
//   clk, reset      - clock; asynchronous active-low reset
//   mem_*           - instruction arriving from the MEM stage
//   wb_stall        - hold the MEM/WB register, no capture and no retire
//   reg_write, rd,
//   write_data      - register-file write port
//   wb_valid        - WB register holds a real instruction
//   instret         - retired-instruction count, wraps at 2^64
module wb_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd,
  input  logic [1:0]  mem_wb_sel,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_load_data,
  input  logic [31:0] mem_pc_plus4,
  input  logic        wb_stall,
  output logic        reg_write,
  output logic [4:0]  rd,
  output logic [31:0] write_data,
  output logic        wb_valid,
  output logic [63:0] instret
);

  logic        valid_q, valid_d;
  logic        reg_write_q, reg_write_d;
  logic [4:0]  rd_q, rd_d;
  logic [1:0]  wb_sel_q, wb_sel_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] load_data_q, load_data_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic [63:0] instret_q, instret_d;

  // Next-state: capture when not stalled; a bubble never carries a write.
  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    rd_d         = rd_q;
    wb_sel_d     = wb_sel_q;
    funct3_d     = funct3_q;
    alu_result_d = alu_result_q;
    load_data_d  = load_data_q;
    pc_plus4_d   = pc_plus4_q;
    instret_d    = instret_q;
    if (!wb_stall) begin
      valid_d      = mem_valid;
      reg_write_d  = mem_valid & mem_reg_write;
      rd_d         = mem_rd;
      wb_sel_d     = mem_wb_sel;
      funct3_d     = mem_funct3;
      alu_result_d = mem_alu_result;
      load_data_d  = mem_load_data;
      pc_plus4_d   = mem_pc_plus4;
      // The instruction in WB retires as it is replaced.
      if (valid_q) begin
        instret_d = instret_q + 64'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      rd_q         <= 5'd0;
      wb_sel_q     <= 2'b00;
      funct3_q     <= 3'b000;
      alu_result_q <= 32'd0;
      load_data_q  <= 32'd0;
      pc_plus4_q   <= 32'd0;
      instret_q    <= 64'd0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      rd_q         <= rd_d;
      wb_sel_q     <= wb_sel_d;
      funct3_q     <= funct3_d;
      alu_result_q <= alu_result_d;
      load_data_q  <= load_data_d;
      pc_plus4_q   <= pc_plus4_d;
      instret_q    <= instret_d;
    end
  end

  // Load extraction: byte picked by addr[1:0], halfword by addr[1] only.
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_value;

  always_comb begin
    load_byte = 8'd0;
    unique case (alu_result_q[1:0])
      2'd0:    load_byte = load_data_q[7:0];
      2'd1:    load_byte = load_data_q[15:8];
      2'd2:    load_byte = load_data_q[23:16];
      default: load_byte = load_data_q[31:24];
    endcase
    load_half = alu_result_q[1] ? load_data_q[31:16] : load_data_q[15:0];

    load_value = load_data_q;
    case (funct3_q)
      3'b000:  load_value = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_value = {24'd0, load_byte};
      3'b001:  load_value = {{16{load_half[15]}}, load_half};
      3'b101:  load_value = {16'd0, load_half};
      default: load_value = load_data_q;
    endcase
  end

  always_comb begin
    write_data = alu_result_q;
    case (wb_sel_q)
      2'b01:   write_data = load_value;
      2'b10:   write_data = pc_plus4_q;
      default: write_data = alu_result_q;
    endcase
  end

  assign reg_write = valid_q & reg_write_q & (rd_q != 5'd0);
  assign rd        = rd_q;
  assign wb_valid  = valid_q;
  assign instret   = instret_q;

endmodule
